// File: rtl/llr_accumulator_pkg.sv
// rtl/llr_accumulator_pkg.sv - shared width/saturation macros, FSM encoding and helpers for the LLR accumulator
//
// Purpose: common definitions used by the accumulator top, its interface and
// its adder sub-module.
//   `LLR_SW(w, e)   accumulator width derived from message width and guard bits
//   `SAT_MAX(w)     largest signed value representable in w bits
//   `SAT_MIN(w)     smallest signed value representable in w bits
//   llr_state_e     FSM encoding: ST_ACCUM = 1'b0, ST_HOLD = 1'b1
//   cnt_width()     beat-counter width for a given node degree (never 0)
// Ports: none.

`ifndef LLR_ACCUMULATOR_PKG_MACROS
`define LLR_ACCUMULATOR_PKG_MACROS
`define LLR_SW(w, e) ((w) + (e))
`define SAT_MAX(w) ((2 ** ((w) - 1)) - 1)
`define SAT_MIN(w) (-(2 ** ((w) - 1)))
`endif

package llr_accumulator_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } llr_state_e;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_EXTENDED_BITS = 4;
  localparam int DEF_DEGREE        = 6;

  // A degree-1 node still needs a 1-bit counter so the vector is legal.
  function automatic int cnt_width(input int degree);
    return (degree > 1) ? $clog2(degree) : 1;
  endfunction

endpackage

// File: rtl/llr_accumulator_if.sv
// rtl/llr_accumulator_if.sv - message-in / node-sum-out handshake bundle for the LLR accumulator
//
// Purpose: groups the input message stream and the output sum stream.
// Ports (signals):
//   in_valid, in_ready, in_data[WIDTH]          narrow signed LLR message stream
//   out_valid, out_ready, out_data[SW]          extended-width node sum stream
//   out_overflow                                sum left the SW-bit range at some step
//   node_done                                   registered pulse after each sum transfer
// Modports: slave (accumulator side), master (producer/consumer side).

interface llr_if #(
  parameter int WIDTH         = 8,
  parameter int EXTENDED_BITS = 4
);
  localparam int SW = `LLR_SW(WIDTH, EXTENDED_BITS);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [SW-1:0]    out_data;
  logic                    out_overflow;
  logic                    node_done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow, node_done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, node_done
  );
endinterface

// File: rtl/llr_ext_adder.sv
// rtl/llr_ext_adder.sv - combinational SW-bit two's complement add with step overflow and optional clamp
//
// Purpose: one accumulation step, shared with the check-node datapath.
// Optional feature macro: ACC_CLAMP_EN (saturate on overflow instead of wrapping).
// Ports:
//   a, b      in  SW  signed operands
//   sum       out SW  wrapped (or clamped) result
//   ovf_step  out 1   operands share a sign and the wrapped result does not

module llr_ext_adder #(
  parameter int SW = 12
) (
  input  logic signed [SW-1:0] a,
  input  logic signed [SW-1:0] b,
  output logic signed [SW-1:0] sum,
  output logic                 ovf_step
);

`ifdef ACC_CLAMP_EN
  localparam logic signed [SW-1:0] POS_SAT = SW'(`SAT_MAX(SW));
  localparam logic signed [SW-1:0] NEG_SAT = SW'(`SAT_MIN(SW));
`endif

  logic signed [SW-1:0] raw;

  always_comb begin
    raw      = a + b;
    ovf_step = (a[SW-1] == b[SW-1]) && (raw[SW-1] != a[SW-1]);
`ifdef ACC_CLAMP_EN
    // On overflow both operands share a sign; that sign picks the rail.
    if (ovf_step) begin
      sum = a[SW-1] ? NEG_SAT : POS_SAT;
    end else begin
      sum = raw;
    end
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/llr_accumulator.sv
// rtl/llr_accumulator.sv - streaming variable-node accumulator summing DEGREE sign-extended LLR messages
//
// Purpose: accepts WIDTH-bit signed messages, sign-extends them to
// SW = WIDTH+EXTENDED_BITS and emits one SW-bit sum per DEGREE messages.
// Optional feature macro: ACC_CLAMP_EN (saturating steps inside llr_ext_adder).
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   llr_if.slave: in_valid/in_ready/in_data message stream,
//         out_valid/out_ready/out_data/out_overflow sum stream, node_done pulse

module llr_accumulator
  import llr_accumulator_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int EXTENDED_BITS = DEF_EXTENDED_BITS,
  parameter int DEGREE        = DEF_DEGREE
) (
  input logic   clk,
  input logic   rst,
  llr_if.slave  bus
);

  localparam int SW = `LLR_SW(WIDTH, EXTENDED_BITS);
  localparam int CW = cnt_width(DEGREE);
  localparam logic [CW-1:0] LAST = CW'(DEGREE - 1);

  llr_state_e state, state_next;

  logic signed [SW-1:0] acc;
  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] out_data_q;
  logic [CW-1:0]        cnt;
  logic                 ovf;
  logic                 ovf_step;
  logic                 out_overflow_q;
  logic                 node_done_q;
  logic                 in_ready;
  logic                 out_valid;
  logic                 beat;
  logic                 consume;

  assign ext     = SW'(bus.in_data);
  assign beat    = bus.in_valid && in_ready;
  assign consume = out_valid && bus.out_ready;

  llr_ext_adder #(.SW(SW)) u_add (
    .a        (acc),
    .b        (ext),
    .sum      (sum),
    .ovf_step (ovf_step)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (beat && (cnt == LAST)) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        // Ready only when the pending sum leaves this cycle, so a new node can
        // start in the same cycle without overwriting unconsumed output.
        in_ready  = bus.out_ready;
        // A degree-1 node completes on its only beat, so it goes straight
        // back to HOLD with the new sum.
        if (bus.out_ready && !(bus.in_valid && (DEGREE == 1))) begin
          state_next = ST_ACCUM;
        end
      end
      default: state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_ACCUM;
      acc            <= '0;
      cnt            <= '0;
      ovf            <= 1'b0;
      out_data_q     <= '0;
      out_overflow_q <= 1'b0;
      node_done_q    <= 1'b0;
    end else begin
      state       <= state_next;
      node_done_q <= consume;
      case (state)
        ST_ACCUM: begin
          if (beat) begin
            if (cnt == LAST) begin
              out_data_q     <= sum;
              out_overflow_q <= ovf | ovf_step;
              acc            <= '0;
              cnt            <= '0;
              ovf            <= 1'b0;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
              ovf <= ovf | ovf_step;
            end
          end
        end
        ST_HOLD: begin
          if (consume && beat) begin
            if (DEGREE == 1) begin
              // A lone message cannot overflow the wider accumulator.
              out_data_q     <= ext;
              out_overflow_q <= 1'b0;
            end else begin
              acc <= ext;
              cnt <= CW'(1);
              ovf <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.node_done    = node_done_q;

endmodule

// File: tb/tb_llr_accumulator.sv
// tb/tb_llr_accumulator.sv - randomized self-checking bench for llr_accumulator against an arithmetic node-sum model

`timescale 1ns/1ps

module tb_llr_accumulator;

  localparam int W   = 8;
  localparam int E   = 4;
  localparam int D   = 6;
  localparam int SW  = W + E;
  localparam int E2  = 1;
  localparam int D2  = 3;
  localparam int SW2 = W + E2;
`ifdef ACC_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  llr_if #(.WIDTH(W), .EXTENDED_BITS(E))  bus ();
  llr_if #(.WIDTH(W), .EXTENDED_BITS(E2)) bus2 ();

  llr_accumulator #(.WIDTH(W), .EXTENDED_BITS(E), .DEGREE(D)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  llr_accumulator #(.WIDTH(W), .EXTENDED_BITS(E2), .DEGREE(D2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: true integer sum per step, then wrap or clamp into sw bits.
  function automatic int add_step(input int acc, input int x, input int sw, output bit o);
    int s, mx, mn;
    s  = acc + x;
    mx = (1 << (sw - 1)) - 1;
    mn = -(1 << (sw - 1));
    o  = (s > mx) || (s < mn);
    if (!o) return s;
    if (CLAMP) return (s > mx) ? mx : mn;
    return (s > mx) ? s - (1 << sw) : s + (1 << sw);
  endfunction

  typedef struct { int sum; bit ovf; } node_t;

  node_t exp_q[$];
  int    in_q[$];
  int    m_acc = 0;
  int    m_cnt = 0;
  bit    m_ovf = 1'b0;

  int vprob = 100, rprob = 100, stall = 0;
  int cyc = 0, done_cnt = 0, last_sum = 0;
  bit last_ovf = 1'b0;

  task automatic model_beat(input int x);
    bit o;
    node_t nd;
    m_acc = add_step(m_acc, x, SW, o);
    m_ovf = m_ovf | o;
    m_cnt++;
    if (m_cnt == D) begin
      nd.sum = m_acc;
      nd.ovf = m_ovf;
      exp_q.push_back(nd);
      m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
    end
  endtask

  task automatic tick();
    bit ev, cons, beat;
    if ((in_q.size() > 0) && ($urandom_range(99) < vprob)) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(in_q[0]);
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = W'($urandom);
    end
    ev = (exp_q.size() > 0);
    if (ev && (stall > 0)) begin
      bus.out_ready = 1'b0;
      stall--;
    end else begin
      bus.out_ready = ($urandom_range(99) < rprob);
    end
    @(negedge clk);
    check("out_valid", bus.out_valid, ev);
    check("in_ready", bus.in_ready, !ev || bus.out_ready);
    if (ev) begin
      check("out_data", $signed(bus.out_data), exp_q[0].sum);
      check("out_overflow", bus.out_overflow, exp_q[0].ovf);
    end
    cons = ev && bus.out_ready;
    beat = bus.in_valid && (!ev || bus.out_ready);
    if (cons) begin
      last_sum = int'($signed(bus.out_data));
      last_ovf = bus.out_overflow;
      void'(exp_q.pop_front());
    end
    if (beat) model_beat(in_q.pop_front());
    @(posedge clk);
    #1;
    check("node_done", bus.node_done, cons);
    if (bus.node_done) done_cnt++;
    cyc++;
  endtask

  task automatic run(input int max_cycles);
    cyc = 0;
    done_cnt = 0;
    while (((in_q.size() > 0) || (exp_q.size() > 0)) && (cyc < max_cycles)) tick();
    check("run_bound_left", in_q.size() + exp_q.size(), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_q.delete();
    exp_q.delete();
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", $signed(bus.out_data), 0);
    check("rst_out_overflow", bus.out_overflow, 0);
    check("rst_node_done", bus.node_done, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst2_out_valid", bus2.out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  // Three-beat node on the narrow-guard instance; returns the DUT's sum.
  task automatic feed2(input int v0, input int v1, input int v2, output int s, output bit o);
    int vals[3];
    int ma;
    bit mo, so;
    vals = '{v0, v1, v2};
    ma = 0;
    mo = 1'b0;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = W'(vals[i]);
      ma = add_step(ma, vals[i], SW2, so);
      mo = mo | so;
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0;
    @(negedge clk);
    check("ovf_out_valid", bus2.out_valid, 1);
    s = int'($signed(bus2.out_data));
    o = bus2.out_overflow;
    check("ovf_model_sum", s, ma);
    check("ovf_model_flag", o, mo);
    @(posedge clk);
    #1;
    check("ovf_node_done", bus2.node_done, 1);
    bus2.out_ready = 1'b0;
  endtask

  initial begin
    int s2;
    bit o2;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Basic sum
    vprob = 100; rprob = 100;
    in_q = '{10, -3, 20, 5, -7, 1};
    run(100);
    check("basic_sum", last_sum, 26);
    check("basic_ovf", last_ovf, 0);
    check("basic_done_pulses", done_cnt, 1);

    // Negative extreme
    in_q = '{-128, -128, -128, -128, -128, -128};
    run(100);
    check("neg_extreme_sum", last_sum, -768);
    check("neg_extreme_ovf", last_ovf, 0);

    // Backpressure with a waiting beat
    stall = 5;
    for (int i = 0; i < 2 * D; i++) in_q.push_back(int'($urandom_range(255)) - 128);
    run(200);
    check("bp_stall_used", stall, 0);
    check("bp_done_pulses", done_cnt, 2);

    // Streaming, no bubbles
    for (int i = 0; i < 3 * D; i++) in_q.push_back(int'($urandom_range(255)) - 128);
    run(200);
    check("stream_cycles", cyc, 3 * D + 1);
    check("stream_done_pulses", done_cnt, 3);

    // Reset mid-node
    in_q = '{50, 50, 50};
    run(100);
    do_reset();
    in_q = '{1, 1, 1, 1, 1, 1};
    run(100);
    check("rst_mid_sum", last_sum, 6);
    check("rst_mid_ovf", last_ovf, 0);

    // Randomized traffic
    for (int r = 0; r < 6; r++) begin
      vprob = 30 + int'($urandom_range(70));
      rprob = 30 + int'($urandom_range(70));
      for (int i = 0; i < 8 * D; i++) begin
        if ($urandom_range(3) == 0) in_q.push_back(($urandom_range(1) == 1) ? 127 : -128);
        else in_q.push_back(int'($urandom_range(255)) - 128);
      end
      run(2000);
    end

    // Overflow on the one-guard-bit, degree-3 instance
    feed2(127, 127, 127, s2, o2);
    check("ovf_pos_sum", s2, CLAMP ? 255 : -131);
    check("ovf_pos_flag", o2, 1);
    feed2(-128, -128, -128, s2, o2);
    check("ovf_neg_sum", s2, CLAMP ? -256 : 128);
    check("ovf_neg_flag", o2, 1);
    feed2(100, -50, 27, s2, o2);
    check("ovf_none_sum", s2, 77);
    check("ovf_none_flag", o2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/llr_accumulator.md
Name: llr_accumulator

Overview:
- Streaming variable-node accumulator for the min-sum decoder datapath. It is the widening counterpart of the narrowing saturation stage.
- Accepts narrow WIDTH-bit signed LLR messages over a valid/ready interface and sign-extends each to WIDTH+EXTENDED_BITS.
- Sums DEGREE messages per node and emits one extended-width sum per node. The saturation stage narrows that sum back to WIDTH.

Parameters:
- WIDTH, 8, message width in bits, two's complement.
- EXTENDED_BITS, 4, guard bits added to the accumulator; sum width is SW = WIDTH+EXTENDED_BITS.
- DEGREE, 6, messages summed per node; legal range is 1 or more.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream message valid.
- in_ready  out  1  block can accept a message this cycle.
- in_data  in  WIDTH  signed LLR message.
- out_valid  out  1  node sum available.
- out_ready  in  1  downstream accepts the sum.
- out_data  out  SW  signed node sum.
- out_overflow  out  1  sticky flag: this node's sum left the SW-bit range at some step.
- node_done  out  1  one-cycle pulse when a sum transfer completes (out_valid&&out_ready).

Behaviour:
- Decided interface facts: one clock; the reset is synchronous and active-high; the ports are named clk and rst.
- Reset values: state=ACCUM, acc=0, cnt=0, out_valid=0, out_data=0, out_overflow=0, node_done=0.
- Transfer definitions: a beat is accepted when in_valid&&in_ready. A sum is consumed when out_valid&&out_ready.
- Extension: ext(in_data) is in_data sign-extended to SW bits. Addition is SW-bit two's complement.
- Step overflow ovf_step: both operand signs are equal and the result sign differs.
- FSM has two states, ACCUM and HOLD.
- ACCUM state:
  - in_ready=1.
  - On an accepted beat, with cnt<DEGREE-1: acc<=acc+ext, cnt<=cnt+1, ovf<=ovf|ovf_step.
  - On an accepted beat, with cnt==DEGREE-1: out_data<=acc+ext, out_overflow<=ovf|ovf_step, out_valid<=1, acc<=0, cnt<=0, ovf<=0, next state HOLD.
  - With no accepted beat, all state holds.
- HOLD state:
  - out_valid=1; out_data and out_overflow are stable until the sum is consumed.
  - in_ready=out_ready, so a consume and the first beat of the next node can occur in the same cycle.
  - On consume with no beat accepted: out_valid<=0, next state ACCUM.
  - On consume with a beat accepted: acc<=ext, cnt<=1, ovf<=0.
    - If DEGREE==1, out_data is reloaded immediately and the FSM stays in HOLD.
    - Otherwise the FSM moves to ACCUM.
  - With out_ready=0: in_ready=0 and nothing changes.
- Latency: out_valid rises the cycle after the DEGREE-th beat is accepted.
- Throughput: one node per DEGREE cycles when out_ready is held high.
- node_done is registered: it is high the cycle after each consume.
- rst asserted mid-node discards the partial sum and any pending output; the block returns to reset values on the next edge.
- The block never drops or duplicates a beat. out_valid never falls without a consume.

Optional Feature:
- Macro ACC_CLAMP_EN.
- When defined: each step whose ovf_step=1 stores +(2^(SW-1)-1) if the operands are positive, or -2^(SW-1) if negative, instead of the wrapped value. The final out_data is clamped the same way. out_overflow is still reported.
- When undefined: the accumulator wraps modulo 2^SW, and out_overflow is the only indication.

Decomposition:
- Shared header (alongside the existing constants header):
  - SW derivation macro.
  - SAT_MAX(w) and SAT_MIN(w) constant macros.
  - FSM state encodings ST_ACCUM=1'b0 and ST_HOLD=1'b1.
- One natural sub-module: llr_ext_adder, the combinational SW-bit add with ovf_step and the optional clamp. It is reusable by the check-node side.

Test Plan:
- Basic sum: WIDTH=8, EXT=4, DEGREE=6, inputs 10,-3,20,5,-7,1 with out_ready=1 -> out_data=26 one cycle after the 6th beat, out_overflow=0, node_done pulses once.
- Negative extreme: six beats of -128 -> out_data=-768 (12'hD00), out_overflow=0.
- Backpressure: out_ready=0 for 5 cycles after a sum -> in_ready=0 and out_data stable throughout. Then out_ready=1 together with a new beat -> the beat is accepted and the next sum is correct.
- Streaming: 3 nodes back-to-back with in_valid and out_ready held high -> 18 beats in 18 cycles, 3 correct sums, no bubbles.
- Overflow: EXT=1, DEGREE=3, inputs 127,127,127 -> without the macro out_data=-131 and out_overflow=1; with ACC_CLAMP_EN out_data=255 and out_overflow=1.
- Reset mid-node: 3 beats of 50, then rst for 1 cycle, then 6 beats of 1 -> out_data=6 and out_overflow=0.
